// File: rtl/pwm_capture_if.sv
// Bundles the measured-pulse input with the period/high-time results and
// status flags; the capture block is the master of the result signals.
interface pwm_capture_if #(
    parameter int CNT_WIDTH = 24
);
    logic                 pwm_in;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] high_time;
    logic                 valid;
    logic                 timeout;
    logic                 stuck_lvl;

    modport master (
        input  pwm_in,
        output period, high_time, valid, timeout, stuck_lvl
    );

    modport slave (
        output pwm_in,
        input  period, high_time, valid, timeout, stuck_lvl
    );
endinterface

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous pulse input in clk cycles.
// A period is reported on every rising edge after the first reference edge;
// a missing rising edge for TIMEOUT cycles drops back to IDLE and flags it.
module pwm_capture #(
    parameter int CNT_WIDTH   = 24,
    parameter int TIMEOUT     = 12000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    pwm_capture_if.master  bus
);
    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TO_VAL = CNT_WIDTH'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   hi_lat_q, hi_lat_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d;
    logic [CNT_WIDTH-1:0]   high_time_q, high_time_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    logic                   stuck_lvl_q, stuck_lvl_d;

    logic                   s;
    logic                   rise;
    logic                   fall;
    logic [CNT_WIDTH-1:0]   cnt_inc;

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~s_d_q;
    assign fall    = ~s & s_d_q;
    assign cnt_inc = cnt_q + ONE;

    // Next-state logic: synchronizer shift, edge bookkeeping and measurement FSM.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
        s_d_d       = s;
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_lat_d    = hi_lat_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;
        stuck_lvl_d = stuck_lvl_q;

        case (state_q)
            IDLE: begin
                // No reference edge yet: the first rise only arms the counter.
                cnt_d = '0;
                if (rise) begin
                    state_d   = MEASURE;
                    timeout_d = 1'b0;
                end
            end
            MEASURE: begin
                cnt_d = cnt_inc;
                // The rise cycle counts as the first high cycle, hence cnt+1.
                if (fall) begin
                    hi_lat_d = cnt_inc;
                end
                if (rise) begin
                    period_d    = cnt_inc;
                    high_time_d = hi_lat_q;
                    valid_d     = 1'b1;
                    cnt_d       = '0;
                end else if (cnt_inc == TO_VAL) begin
                    // Keep the last results; only the status flags change.
                    state_d     = IDLE;
                    timeout_d   = 1'b1;
                    stuck_lvl_d = s;
                    cnt_d       = '0;
                    hi_lat_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset discards any measurement in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            s_d_q       <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_lat_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            stuck_lvl_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            s_d_q       <= s_d_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_lat_q    <= hi_lat_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            stuck_lvl_q <= stuck_lvl_d;
        end
    end

    assign bus.period    = period_q;
    assign bus.high_time = high_time_q;
    assign bus.valid     = valid_q;
    assign bus.timeout   = timeout_q;
    assign bus.stuck_lvl = stuck_lvl_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with TIMEOUT=1000, SYNC_STAGES=2.
module tb_pwm_capture;
    localparam int CW = 24;

    logic clk;
    logic rst;

    pwm_capture_if #(.CNT_WIDTH(CW)) dut_if ();

    pwm_capture #(
        .CNT_WIDTH   (CW),
        .TIMEOUT     (1000),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if.master)
    );

    int pass_cnt = 0;
    int total    = 0;

    // Negedge monitor: counts valid strobes and latches the reported values.
    int          ncnt     = 0;
    int          vcnt     = 0;
    int          valid_at = 0;
    logic [CW-1:0] last_per = '0;
    logic [CW-1:0] last_hi  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        ncnt <= ncnt + 1;
        if (dut_if.valid) begin
            vcnt     <= vcnt + 1;
            valid_at <= ncnt + 1;
            last_per <= dut_if.period;
            last_hi  <= dut_if.high_time;
        end
    end

    // One PWM period starting just after a posedge: hi cycles high, per total.
    task automatic pwm_period(input int hi, input int per);
        dut_if.pwm_in = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        dut_if.pwm_in = 1'b0;
        repeat (per - hi) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        dut_if.pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (dut_if.period !== 24'd0) $display("FAIL reset_period got %0d want 0", dut_if.period); else pass_cnt++;
        total++; if (dut_if.high_time !== 24'd0) $display("FAIL reset_high got %0d want 0", dut_if.high_time); else pass_cnt++;
        total++; if (dut_if.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", dut_if.valid); else pass_cnt++;
        total++; if (dut_if.timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", dut_if.timeout); else pass_cnt++;
        total++; if (dut_if.stuck_lvl !== 1'b0) $display("FAIL reset_stuck got %b want 0", dut_if.stuck_lvl); else pass_cnt++;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int base;
        int n0;
        base = vcnt;
        repeat (3) pwm_period(25, 100);
        total++; if (vcnt - base !== 2) $display("FAIL basic_count got %0d want 2", vcnt - base); else pass_cnt++;
        n0 = ncnt;
        pwm_period(25, 100);
        total++; if (vcnt - base !== 3) $display("FAIL basic_count4 got %0d want 3", vcnt - base); else pass_cnt++;
        total++; if (valid_at !== n0 + 4) $display("FAIL basic_latency got %0d want %0d", valid_at - n0, 4); else pass_cnt++;
        total++; if (last_per !== 24'd100) $display("FAIL basic_period got %0d want 100", last_per); else pass_cnt++;
        total++; if (last_hi !== 24'd25) $display("FAIL basic_high got %0d want 25", last_hi); else pass_cnt++;
    endtask

    task automatic test_short_duty;
        int base;
        base = vcnt;
        repeat (3) pwm_period(1, 10);
        total++; if (vcnt - base !== 3) $display("FAIL duty1_count got %0d want 3", vcnt - base); else pass_cnt++;
        total++; if (last_per !== 24'd10) $display("FAIL duty1_period got %0d want 10", last_per); else pass_cnt++;
        total++; if (last_hi !== 24'd1) $display("FAIL duty1_high got %0d want 1", last_hi); else pass_cnt++;
        repeat (3) pwm_period(9, 10);
        total++; if (vcnt - base !== 6) $display("FAIL duty9_count got %0d want 6", vcnt - base); else pass_cnt++;
        total++; if (last_per !== 24'd10) $display("FAIL duty9_period got %0d want 10", last_per); else pass_cnt++;
        total++; if (last_hi !== 24'd9) $display("FAIL duty9_high got %0d want 9", last_hi); else pass_cnt++;
    endtask

    task automatic test_timeout_low;
        int base;
        base = vcnt;
        repeat (980) @(posedge clk);
        #1;
        total++; if (dut_if.timeout !== 1'b0) $display("FAIL tlow_early got %b want 0", dut_if.timeout); else pass_cnt++;
        repeat (20) @(posedge clk);
        #1;
        total++; if (dut_if.timeout !== 1'b1) $display("FAIL tlow_set got %b want 1", dut_if.timeout); else pass_cnt++;
        total++; if (dut_if.stuck_lvl !== 1'b0) $display("FAIL tlow_stuck got %b want 0", dut_if.stuck_lvl); else pass_cnt++;
        total++; if (dut_if.period !== 24'd10) $display("FAIL tlow_period got %0d want 10", dut_if.period); else pass_cnt++;
        total++; if (dut_if.high_time !== 24'd9) $display("FAIL tlow_high got %0d want 9", dut_if.high_time); else pass_cnt++;
        pwm_period(5, 40);
        total++; if (dut_if.timeout !== 1'b0) $display("FAIL tlow_clear got %b want 0", dut_if.timeout); else pass_cnt++;
        total++; if (vcnt - base !== 0) $display("FAIL tlow_novalid got %0d want 0", vcnt - base); else pass_cnt++;
    endtask

    task automatic test_timeout_high;
        int base;
        base = vcnt;
        dut_if.pwm_in = 1'b1;
        repeat (1020) @(posedge clk);
        #1;
        total++; if (vcnt - base !== 1) $display("FAIL thigh_count got %0d want 1", vcnt - base); else pass_cnt++;
        total++; if (last_per !== 24'd40) $display("FAIL thigh_prev_period got %0d want 40", last_per); else pass_cnt++;
        total++; if (last_hi !== 24'd5) $display("FAIL thigh_prev_high got %0d want 5", last_hi); else pass_cnt++;
        total++; if (dut_if.timeout !== 1'b1) $display("FAIL thigh_set got %b want 1", dut_if.timeout); else pass_cnt++;
        total++; if (dut_if.stuck_lvl !== 1'b1) $display("FAIL thigh_stuck got %b want 1", dut_if.stuck_lvl); else pass_cnt++;
        dut_if.pwm_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        pwm_period(20, 50);
        total++; if (dut_if.timeout !== 1'b0) $display("FAIL thigh_clear got %b want 0", dut_if.timeout); else pass_cnt++;
        total++; if (vcnt - base !== 1) $display("FAIL thigh_first_rise got %0d want 1", vcnt - base); else pass_cnt++;
        pwm_period(20, 50);
        total++; if (vcnt - base !== 2) $display("FAIL thigh_second_rise got %0d want 2", vcnt - base); else pass_cnt++;
        total++; if (last_per !== 24'd50) $display("FAIL thigh_period got %0d want 50", last_per); else pass_cnt++;
        total++; if (last_hi !== 24'd20) $display("FAIL thigh_high got %0d want 20", last_hi); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int base;
        dut_if.pwm_in = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (dut_if.period !== 24'd0) $display("FAIL rmid_period got %0d want 0", dut_if.period); else pass_cnt++;
        total++; if (dut_if.high_time !== 24'd0) $display("FAIL rmid_high got %0d want 0", dut_if.high_time); else pass_cnt++;
        total++; if (dut_if.stuck_lvl !== 1'b0) $display("FAIL rmid_stuck got %b want 0", dut_if.stuck_lvl); else pass_cnt++;
        dut_if.pwm_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        base = vcnt;
        pwm_period(30, 80);
        total++; if (vcnt - base !== 0) $display("FAIL rmid_first got %0d want 0", vcnt - base); else pass_cnt++;
        total++; if (dut_if.period !== 24'd0) $display("FAIL rmid_hold got %0d want 0", dut_if.period); else pass_cnt++;
        pwm_period(30, 80);
        total++; if (vcnt - base !== 1) $display("FAIL rmid_second got %0d want 1", vcnt - base); else pass_cnt++;
        total++; if (last_per !== 24'd80) $display("FAIL rmid_period_val got %0d want 80", last_per); else pass_cnt++;
        total++; if (last_hi !== 24'd30) $display("FAIL rmid_high_val got %0d want 30", last_hi); else pass_cnt++;
    endtask

    task automatic test_duty_change;
        int base;
        base = vcnt;
        repeat (2) pwm_period(30, 100);
        total++; if (vcnt - base !== 2) $display("FAIL duty_c30_count got %0d want 2", vcnt - base); else pass_cnt++;
        total++; if (last_hi !== 24'd30) $display("FAIL duty_c30_high got %0d want 30", last_hi); else pass_cnt++;
        pwm_period(70, 100);
        total++; if (vcnt - base !== 3) $display("FAIL duty_c70a_count got %0d want 3", vcnt - base); else pass_cnt++;
        total++; if (last_hi !== 24'd30) $display("FAIL duty_c70a_high got %0d want 30", last_hi); else pass_cnt++;
        pwm_period(70, 100);
        total++; if (vcnt - base !== 4) $display("FAIL duty_c70b_count got %0d want 4", vcnt - base); else pass_cnt++;
        total++; if (last_per !== 24'd100) $display("FAIL duty_c70b_period got %0d want 100", last_per); else pass_cnt++;
        total++; if (last_hi !== 24'd70) $display("FAIL duty_c70b_high got %0d want 70", last_hi); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        dut_if.pwm_in = 1'b0;
        test_reset();
        test_basic();
        test_short_duty();
        test_timeout_low();
        test_timeout_high();
        test_reset_mid();
        test_duty_change();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
